video_pattern_checker: RTL and testbench
========================================

# video_pattern_checker

Sink-side checker for the colour-band test video stream. It sits on the hs/vs/de/rgb bus at the output of the pattern generator, or after a loop-back through the HDMI path. Per frame it measures the active geometry, compares every active pixel against the expected vertical-band pattern, and reports frame status, error counts and a lock indication to the bench or to a status register.

## Interface
- `LOCK_FRAMES`, 2: consecutive good frames with identical geometry required before `locked` asserts (1..15).
- `VS_ACTIVE_HIGH`, 1: 1 means vs is active-high; 0 means active-low.
- `clk` in 1: pixel clock, the only clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `hs` in 1: horizontal sync. Pipelined only; not used for measurement.
- `vs` in 1: vertical sync. Its leading edge marks a frame boundary.
- `de` in 1: data enable; high on active pixels.
- `rgb_r`, `rgb_g`, `rgb_b` in 8 each: pixel data, valid when de=1.
- `hactive_meas` out 16: active width, latched from the first line of the last closed frame.
- `vactive_meas` out 16: active line count of the last closed frame.
- `frame_cnt` out 16: number of closed frames. Wraps at 0xFFFF.
- `err_cnt` out 16: pixel mismatches in the last closed frame. Saturates at 0xFFFF.
- `frame_done` out 1: one-cycle pulse when a frame closes.
- `frame_ok` out 1: last closed frame had zero pixel errors and all lines equal width.
- `locked` out 1: stream is stable and correct.

## Operation
- Input stage registers vs, de and rgb. A vs leading edge is detected on the registered values.
- Arming:
  - After reset the block is unarmed and ignores all data until the first vs leading edge. That edge arms it and closes nothing.
  - Every later vs leading edge closes the current frame and opens a new one.
- Counters:
  - x counts registered de-high cycles in the current line.
  - y is the line index. It resets to 0 at frame open and increments at each de falling edge.
  - x and y are 16-bit and saturate at 0xFFFF.
- Line-width check:
  - The first line's x is stored as the reference width.
  - Any later line of the same frame with a different x sets a width-error flag for that frame.
- Expected pattern. The band index is a function of y:
  - Band 0: lines 0..254.
  - Band k, k = 1..6: lines 256k−1 .. 256k+254.
  - Band 7: lines 1791 and above.
  - With v = y[7:0], the expected (r,g,b) per band is:
    - 0: (FF,v,v)
    - 1: (v,FF,v)
    - 2: (v,v,FF)
    - 3: (FF,v,FF)
    - 4: (00,00,v)
    - 5: (FF,FF,v)
    - 6: (v,v,v)
    - 7: (00,00,00)
- Comparison: each active pixel whose r, g or b differs from the expected value increments the per-frame error accumulator by 1 (saturating).
- Frame close:
  - Applies only when the frame has y ≥ 1. A frame with no active lines is discarded silently: no pulse and no output updates.
  - hactive_meas takes the first-line width and vactive_meas takes y.
  - err_cnt takes the accumulator.
  - frame_ok = (accumulator == 0) && !width error.
  - frame_cnt increments and frame_done pulses.
  - The accumulator and width flag then clear.
- Lock state machine, states UNLOCKED and LOCKED:
  - A good-frame counter increments on each closed frame with frame_ok=1 and the same geometry as the previous closed frame.
  - Any other closed frame resets the counter to 0 and forces UNLOCKED.
  - The counter reaching LOCK_FRAMES moves the machine to LOCKED.
  - `locked` = state is LOCKED.
- de during vs active is processed normally.
- Reset values: all outputs 0, state UNLOCKED, unarmed.

## Timing
- Pipeline stages:
  - Stage 1: input register.
  - Stage 2: band/expected-value compute and compare.
  - Stage 3: accumulate.
- The frame close waits for stage 3 to drain, so the last pixel of a frame is always counted in that frame.
- frame_done is high in the 3rd cycle after the cycle in which vs is first sampled active. All status outputs update on the same edge and hold until the next close.
- A de falling edge and a vs leading edge in the same cycle: the line is counted before the close.
- Assertion of rst_n mid-frame: everything clears immediately and the block returns to the unarmed state.

## Configuration
- `VIDEO_PATTERN_CHECK_EN` defined: pixel comparison is active as described above.
- `VIDEO_PATTERN_CHECK_EN` undefined:
  - Comparison logic is removed.
  - err_cnt stays 0.
  - frame_ok reflects only the line-width check.
  - Geometry measurement, frame_cnt and lock are unchanged.

## Test plan
- Clean 1920x1080 band stream, 4 frames → each close gives hactive_meas=1920, vactive_meas=1080, err_cnt=0, frame_ok=1. locked=1 after the 2nd closed frame (the 3rd vs edge after reset); frame_cnt=4 after the 5th vs edge.
- Same stream with rgb_g bit 0 flipped at line 300, pixel 10 → that frame gives err_cnt=1 and frame_ok=0, and locked drops. The next clean frame gives err_cnt=0, and locked re-asserts after 2 good frames.
- Line 5 shortened to 1919 pixels → frame_ok=0, err_cnt=0, hactive_meas=1920.
- Band boundary sweep with 64-pixel lines and 2048 lines → err_cnt=0. Additionally:
  - Lines 254/255 as band 0 instead of band 1 → err_cnt=64.
  - Lines 1790/1791 as band 6 instead of band 7 → err_cnt=64.
- rst_n pulsed low in mid-frame → all outputs 0 immediately. The next vs edge only arms, with no frame_done; the following vs edge closes a frame normally.
- Build without the macro, with a corrupted pixel → err_cnt=0, frame_ok=1. Two vs edges with no de in between → no frame_done.

Source files
------------

// File: rtl/video_pattern_checker_if.sv
// Video bus from the colour-band pattern source to the checker.
// The source drives the master modport and the checker reads the slave modport.
interface video_pattern_checker_if;
  logic       hs;
  logic       vs;
  logic       de;
  logic [7:0] rgb_r;
  logic [7:0] rgb_g;
  logic [7:0] rgb_b;

  modport master (output hs, vs, de, rgb_r, rgb_g, rgb_b);
  modport slave  (input  hs, vs, de, rgb_r, rgb_g, rgb_b);
endinterface

// File: rtl/video_pattern_checker.sv
// Colour-band stream checker: per-frame geometry, pixel errors and lock status.
// Pixel comparison is built only when VIDEO_PATTERN_CHECK_EN is defined.
module video_pattern_checker #(
  parameter int LOCK_FRAMES    = 2,
  parameter bit VS_ACTIVE_HIGH = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  video_pattern_checker_if.slave        bus,
  output logic [15:0]                   hactive_meas,
  output logic [15:0]                   vactive_meas,
  output logic [15:0]                   frame_cnt,
  output logic [15:0]                   err_cnt,
  output logic                          frame_done,
  output logic                          frame_ok,
  output logic                          locked
);
  typedef enum logic {UNLOCKED, LOCKED} lock_t;

  localparam logic [15:0] SAT    = 16'hFFFF;
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  logic s1_vs, s1_vs_d, s1_de, s1_de_d, s1_hs;
  logic rise, fall, act, armed, close;
  logic unused_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vs   <= 1'b0;
      s1_vs_d <= 1'b0;
      s1_de   <= 1'b0;
      s1_de_d <= 1'b0;
      s1_hs   <= 1'b0;
    end else begin
      s1_vs   <= VS_ACTIVE_HIGH ? bus.vs : ~bus.vs;
      s1_vs_d <= s1_vs;
      s1_de   <= bus.de;
      s1_de_d <= s1_de;
      s1_hs   <= bus.hs;
    end
  end

  assign unused_hs = s1_hs;
  assign rise      = s1_vs & ~s1_vs_d;
  assign fall      = s1_de_d & ~s1_de;
  // The pixel beside the arming edge already belongs to the first frame.
  assign act       = armed | rise;

  // Geometry: a line ending on the vs edge itself is folded in before the snapshot.
  logic [15:0] x, y, ref_w, y_line, ref_line;
  logic        werr, werr_line;
  logic [15:0] snap_y, snap_w;
  logic        snap_werr;

  always_comb begin
    y_line    = y;
    ref_line  = ref_w;
    werr_line = werr;
    if (fall) begin
      y_line = (y == SAT) ? y : y + 16'd1;
      if (y == 16'd0)      ref_line  = x;
      else if (x != ref_w) werr_line = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      close     <= 1'b0;
      x         <= '0;
      y         <= '0;
      ref_w     <= '0;
      werr      <= 1'b0;
      snap_y    <= '0;
      snap_w    <= '0;
      snap_werr <= 1'b0;
    end else begin
      close <= rise & armed;
      if (rise) armed <= 1'b1;
      if (act) begin
        if (fall)                  x <= '0;
        else if (s1_de && x != SAT) x <= x + 16'd1;
        if (rise) begin
          snap_y    <= y_line;
          snap_w    <= ref_line;
          snap_werr <= werr_line;
          y         <= '0;
          werr      <= 1'b0;
        end else begin
          y     <= y_line;
          ref_w <= ref_line;
          werr  <= werr_line;
        end
      end
    end
  end

  logic s2_mis;

`ifdef VIDEO_PATTERN_CHECK_EN
  logic [7:0]  s1_r, s1_g, s1_b, v;
  logic [15:0] y_cmp;
  logic [2:0]  band;
  logic [23:0] expd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= '0;
      s1_g <= '0;
      s1_b <= '0;
    end else begin
      s1_r <= bus.rgb_r;
      s1_g <= bus.rgb_g;
      s1_b <= bus.rgb_b;
    end
  end

  // Bands are 256 lines long but start one line early: band = (y+1)/256, capped at 7.
  always_comb begin
    y_cmp = rise ? 16'd0 : y;
    v     = y_cmp[7:0];
    if (y_cmp >= 16'd1791) band = 3'd7;
    else                   band = 3'((y_cmp + 16'd1) >> 8);
    case (band)
      3'd0:    expd = {8'hFF, v, v};
      3'd1:    expd = {v, 8'hFF, v};
      3'd2:    expd = {v, v, 8'hFF};
      3'd3:    expd = {8'hFF, v, 8'hFF};
      3'd4:    expd = {8'h00, 8'h00, v};
      3'd5:    expd = {8'hFF, 8'hFF, v};
      3'd6:    expd = {v, v, v};
      default: expd = 24'h000000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s2_mis <= 1'b0;
    else        s2_mis <= act & s1_de & ({s1_r, s1_g, s1_b} != expd);
  end
`else
  logic unused_rgb;
  assign unused_rgb = ^{bus.rgb_r, bus.rgb_g, bus.rgb_b};
  assign s2_mis     = 1'b0;
`endif

  // Close lands one cycle after the edge so the old frame's last mismatch is already in acc;
  // the mismatch arriving on the close edge is the new frame's first pixel.
  logic [15:0] acc;
  logic        close_ok, ok_nxt, same_geom, good, have_prev;

  assign close_ok  = close && (snap_y != 16'd0);
  assign ok_nxt    = (acc == 16'd0) && !snap_werr;
  // The first closed frame has no predecessor, so it counts as matching geometry.
  assign same_geom = !have_prev || (snap_w == hactive_meas && snap_y == vactive_meas);
  assign good      = ok_nxt && same_geom;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      hactive_meas <= '0;
      vactive_meas <= '0;
      frame_cnt    <= '0;
      err_cnt      <= '0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      have_prev    <= 1'b0;
    end else begin
      frame_done <= close_ok;
      if (close)                      acc <= {15'd0, s2_mis};
      else if (s2_mis && acc != SAT)  acc <= acc + 16'd1;
      if (close_ok) begin
        hactive_meas <= snap_w;
        vactive_meas <= snap_y;
        err_cnt      <= acc;
        frame_ok     <= ok_nxt;
        frame_cnt    <= frame_cnt + 16'd1;
        have_prev    <= 1'b1;
      end
    end
  end

  lock_t      state, state_nxt;
  logic [3:0] good_cnt, good_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNLOCKED;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    if (close_ok) begin
      if (good) begin
        if (good_cnt < LOCK_N)       good_cnt_nxt = good_cnt + 4'd1;
        if (good_cnt_nxt >= LOCK_N)  state_nxt    = LOCKED;
      end else begin
        good_cnt_nxt = '0;
        state_nxt    = UNLOCKED;
      end
    end
  end

  assign locked = (state == LOCKED);
endmodule

// File: tb/tb_video_pattern_checker.sv
// Directed bench for video_pattern_checker: small frames plus a 4x2048 band sweep.
// Expected error counts follow whether VIDEO_PATTERN_CHECK_EN is defined for the build.
module tb_video_pattern_checker;
`ifdef VIDEO_PATTERN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] hactive_meas, vactive_meas, frame_cnt, err_cnt;
  logic        frame_done, frame_ok, locked;
  int          errors = 0, checks = 0, done_cnt = 0;

  video_pattern_checker_if vif ();

  video_pattern_checker #(.LOCK_FRAMES(2), .VS_ACTIVE_HIGH(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (vif),
    .hactive_meas (hactive_meas),
    .vactive_meas (vactive_meas),
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt),
    .frame_done   (frame_done),
    .frame_ok     (frame_ok),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation still running, want finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int band_of(input int y);
    if (y <= 254)  return 0;
    if (y >= 1791) return 7;
    for (int k = 1; k <= 6; k++)
      if (y >= 256*k - 1 && y <= 256*k + 254) return k;
    return 7;
  endfunction

  function automatic logic [23:0] band_px(input int k, input logic [7:0] v);
    case (k)
      0:       return {8'hFF, v, v};
      1:       return {v, 8'hFF, v};
      2:       return {v, v, 8'hFF};
      3:       return {8'hFF, v, 8'hFF};
      4:       return {8'h00, 8'h00, v};
      5:       return {8'hFF, 8'hFF, v};
      6:       return {v, v, v};
      default: return 24'h000000;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      vif.de = 1'b0;
      vif.vs = 1'b0;
    end
  endtask

  // vs pulse of two cycles; frame_done must be high exactly in the 3rd cycle after sampling.
  task automatic vs_edge(input bit exp_done);
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    vif.vs = 1'b1;
    vif.de = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (i == 2) vif.vs = 1'b0;
      @(negedge clk);
      if (i == 3) chk("done_at_3", frame_done, exp_done);
    end
    chk("done_pulses", done_cnt - d0, exp_done);
  endtask

  task automatic lines(input int w, input int h, input int bad_y, input int bad_x,
                       input logic [23:0] mask, input int short_y, input int alt_y,
                       input int alt_band);
    for (int y = 0; y < h; y++) begin
      int          lw, k;
      logic [23:0] px;
      lw = (y == short_y) ? w - 1 : w;
      k  = (y == alt_y) ? alt_band : band_of(y);
      for (int x = 0; x < lw; x++) begin
        px = band_px(k, 8'(y));
        if (y == bad_y && x == bad_x) px ^= mask;
        @(posedge clk); #1;
        vif.de = 1'b1;
        {vif.rgb_r, vif.rgb_g, vif.rgb_b} = px;
      end
      @(posedge clk); #1;
      vif.de = 1'b0;
      vif.hs = 1'b1;
      @(posedge clk); #1;
      vif.hs = 1'b0;
    end
    idle(2);
  endtask

  task automatic clean(input int w, input int h);
    lines(w, h, -1, -1, 24'h0, -1, -1, 0);
  endtask

  task automatic check_frame(input int h, input int v, input int e, input bit ok,
                             input int fc, input bit lk);
    chk("hactive_meas", hactive_meas, h);
    chk("vactive_meas", vactive_meas, v);
    chk("err_cnt", err_cnt, e);
    chk("frame_ok", frame_ok, ok);
    chk("frame_cnt", frame_cnt, fc);
    chk("locked", locked, lk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_hactive"}, hactive_meas, 0);
    chk({tag, "_vactive"}, vactive_meas, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_ok"}, frame_ok, 0);
    chk({tag, "_locked"}, locked, 0);
  endtask

  initial begin
    vif.hs = 1'b0;
    vif.vs = 1'b0;
    vif.de = 1'b0;
    {vif.rgb_r, vif.rgb_g, vif.rgb_b} = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    rst_n = 1'b1;

    // Clean 16x12 stream: lock after the 2nd closed frame
    vs_edge(1'b0);
    for (int f = 1; f <= 4; f++) begin
      clean(16, 12);
      vs_edge(1'b1);
      check_frame(16, 12, 0, 1'b1, f, f >= 2);
    end

    // Green bit 0 flipped at line 3, pixel 10
    lines(16, 12, 3, 10, 24'h000100, -1, -1, 0);
    vs_edge(1'b1);
    check_frame(16, 12, CHK ? 1 : 0, !CHK, 5, !CHK);
    clean(16, 12);
    vs_edge(1'b1);
    check_frame(16, 12, 0, 1'b1, 6, !CHK);
    clean(16, 12);
    vs_edge(1'b1);
    check_frame(16, 12, 0, 1'b1, 7, 1'b1);

    // Line 5 one pixel short
    lines(16, 12, -1, -1, 24'h0, 5, -1, 0);
    vs_edge(1'b1);
    check_frame(16, 12, 0, 1'b0, 8, 1'b0);

    // Reset pulsed in the middle of an active line
    clean(16, 4);
    @(posedge clk); #1;
    vif.de = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge clk); #1;
    vif.de = 1'b0;
    rst_n  = 1'b1;
    vs_edge(1'b0);
    clean(16, 12);
    vs_edge(1'b1);
    check_frame(16, 12, 0, 1'b1, 1, 1'b0);

    // Frame with no active lines is discarded
    vs_edge(1'b0);
    chk("frame_cnt_empty", frame_cnt, 1);

    // Band sweep 4x2048: clean, then line 254 as band 1, then line 1791 as band 6
    clean(4, 2048);
    vs_edge(1'b1);
    check_frame(4, 2048, 0, 1'b1, 2, 1'b0);
    lines(4, 2048, -1, -1, 24'h0, -1, 254, 1);
    vs_edge(1'b1);
    check_frame(4, 2048, CHK ? 4 : 0, !CHK, 3, 1'b0);
    lines(4, 2048, -1, -1, 24'h0, -1, 1791, 6);
    vs_edge(1'b1);
    check_frame(4, 2048, CHK ? 4 : 0, !CHK, 4, !CHK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
